uart_cpu_bridge: RTL and testbench

- Parametrised UART-to-CPU command/result bridge. Sits between the UART RX/TX pair and the BIP CPU.
- Decodes command bytes from RX and drives CPU start/reset pulses.
- On CPU completion, snapshots the accumulator and the clock counter, then streams them LSB-byte-first to TX with a full tx_start/tx_done handshake.
- Adds a resend command and overrun detection over the previous single-shot interface.

---
 rtl/uart_cpu_pkg.sv | 21 ++
 rtl/edge_detect.sv | 19 +
 rtl/uart_cpu_bridge.sv | 146 ++++++++++++++
 tb/tb_uart_cpu_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cpu_pkg.sv
// Shared types for the UART/CPU bridge: FSM state encoding, default command codes, byte-count helper.
// No logic, no latency, no flow control.
package uart_cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RUN     = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SEND    = 3'd3,
      ST_WAIT_TX = 3'd4
   } state_t;

   localparam logic [7:0] CMD_START_DEF  = 8'h01;
   localparam logic [7:0] CMD_RESET_DEF  = 8'h02;
   localparam logic [7:0] CMD_RESEND_DEF = 8'h03;

   function automatic int byte_count(input int w, input int nbit);
      return (w + nbit - 1) / nbit;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: o_rise is combinational (same cycle as i_sig rising), no backpressure.
// Registered copy clears to 0 on reset, so a level already high after reset reads as an edge.
module edge_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_sig,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_prev <= 1'b0;
      else         r_prev <= i_sig;
   end

   assign o_rise = i_sig & ~r_prev;

endmodule

// File: rtl/uart_cpu_bridge.sv
// UART command decoder / CPU result streamer; cmd->cpu_start 1 cycle, byte-to-byte paced by tx_done (2 cycles).
// RX commands arriving while busy are dropped and flag rx_overrun. Macro UART_CPU_BRIDGE_CHECKSUM_EN appends an XOR byte.
module uart_cpu_bridge
   import uart_cpu_pkg::*;
#(
   parameter int NBIT_DATA_LEN = 8,
   parameter int LEN_ACC       = 16,
   parameter int LEN_CLK       = 16,
   parameter logic [NBIT_DATA_LEN-1:0] CMD_START  = NBIT_DATA_LEN'(CMD_START_DEF),
   parameter logic [NBIT_DATA_LEN-1:0] CMD_RESET  = NBIT_DATA_LEN'(CMD_RESET_DEF),
   parameter logic [NBIT_DATA_LEN-1:0] CMD_RESEND = NBIT_DATA_LEN'(CMD_RESEND_DEF)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_rx_done_tick,
   input  logic [NBIT_DATA_LEN-1:0] i_rx_data_in,
   input  logic                     i_tx_done_tick,
   input  logic                     i_cpu_done,
   input  logic [LEN_ACC-1:0]       i_in_acc,
   input  logic [LEN_CLK-1:0]       i_in_clk_count,
   output logic                     o_cpu_start,
   output logic                     o_cpu_reset,
   output logic                     o_tx_start,
   output logic [NBIT_DATA_LEN-1:0] o_data_out,
   output logic                     o_busy,
   output logic                     o_rx_overrun
);

   localparam int ACC_BYTES = byte_count(LEN_ACC, NBIT_DATA_LEN);
   localparam int CLK_BYTES = byte_count(LEN_CLK, NBIT_DATA_LEN);
   localparam int N_DATA    = ACC_BYTES + CLK_BYTES;
`ifdef UART_CPU_BRIDGE_CHECKSUM_EN
   localparam int LAST_IDX  = N_DATA;
`else
   localparam int LAST_IDX  = N_DATA - 1;
`endif
   localparam int IDX_W     = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_IDX);

   logic                              w_rx_evt;
   logic                              w_tx_evt;
   logic [ACC_BYTES*NBIT_DATA_LEN-1:0] w_acc_pad;
   logic [CLK_BYTES*NBIT_DATA_LEN-1:0] w_clk_pad;
   logic [NBIT_DATA_LEN-1:0]          w_byte;
   logic [NBIT_DATA_LEN-1:0]          w_load_byte;

   state_t                            r_state;
   logic [N_DATA*NBIT_DATA_LEN-1:0]   r_snap;
   logic [IDX_W-1:0]                  r_idx;

   edge_detect u_rx_edge (.i_clk(i_clk), .i_reset(i_reset), .i_sig(i_rx_done_tick), .o_rise(w_rx_evt));
   edge_detect u_tx_edge (.i_clk(i_clk), .i_reset(i_reset), .i_sig(i_tx_done_tick), .o_rise(w_tx_evt));

   always_comb begin
      w_acc_pad = '0;
      w_acc_pad[LEN_ACC-1:0] = i_in_acc;
      w_clk_pad = '0;
      w_clk_pad[LEN_CLK-1:0] = i_in_clk_count;
      w_byte = '0;
      for (int i = 0; i < N_DATA; i++) begin
         if (r_idx == IDX_W'(i)) w_byte = r_snap[i*NBIT_DATA_LEN +: NBIT_DATA_LEN];
      end
   end

`ifdef UART_CPU_BRIDGE_CHECKSUM_EN
   logic [NBIT_DATA_LEN-1:0] r_xor;

   // Index one past the data bytes selects the running XOR instead of the snapshot.
   assign w_load_byte = (r_idx == IDX_LAST) ? r_xor : w_byte;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_xor <= '0;
      end else if ((r_state == ST_IDLE && w_rx_evt && i_rx_data_in == CMD_RESEND) ||
                   (r_state == ST_RUN && i_cpu_done && !o_cpu_start)) begin
         r_xor <= '0;
      end else if (r_state == ST_LOAD && r_idx != IDX_LAST) begin
         r_xor <= r_xor ^ w_byte;
      end
   end
`else
   assign w_load_byte = w_byte;
`endif

   assign o_busy = (r_state != ST_IDLE);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_snap       <= '0;
         r_idx        <= '0;
         o_cpu_start  <= 1'b0;
         o_cpu_reset  <= 1'b0;
         o_tx_start   <= 1'b0;
         o_data_out   <= '0;
         o_rx_overrun <= 1'b0;
      end else begin
         o_cpu_start <= 1'b0;
         o_cpu_reset <= 1'b0;
         o_tx_start  <= 1'b0;
         if (w_rx_evt && r_state != ST_IDLE) o_rx_overrun <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (w_rx_evt) begin
                  if (i_rx_data_in == CMD_START) begin
                     o_cpu_start <= 1'b1;
                     r_state     <= ST_RUN;
                  end else if (i_rx_data_in == CMD_RESET) begin
                     o_cpu_reset  <= 1'b1;
                     o_rx_overrun <= 1'b0;
                  end else if (i_rx_data_in == CMD_RESEND) begin
                     r_idx   <= '0;
                     r_state <= ST_LOAD;
                  end
               end
            end
            ST_RUN: begin
               // cpu_done is ignored while the start pulse is still on the wire.
               if (i_cpu_done && !o_cpu_start) begin
                  r_snap  <= {w_clk_pad, w_acc_pad};
                  r_idx   <= '0;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               o_data_out <= w_load_byte;
               o_tx_start <= 1'b1;
               r_state    <= ST_SEND;
            end
            ST_SEND: r_state <= ST_WAIT_TX;
            ST_WAIT_TX: begin
               if (w_tx_evt) begin
                  if (r_idx == IDX_LAST) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx   <= r_idx + 1'b1;
                     r_state <= ST_LOAD;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cpu_bridge.sv
// Randomized bench for uart_cpu_bridge: byte streams and pulse timing checked against a queue-based result model.
module tb_uart_cpu_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rx_tick = 1'b0, tx_tick = 1'b0, cpu_done = 1'b0;
   logic [7:0]  rx_dat = 8'h00;
   logic [15:0] acc = 16'h0, clkc = 16'h0;
   logic        cpu_start, cpu_reset, tx_start, busy, ovr;
   logic [7:0]  dout;

   logic        d2_rx_tick = 1'b0, d2_tx_tick = 1'b0, d2_cpu_done = 1'b0;
   logic [7:0]  d2_rx_dat = 8'h00;
   logic [11:0] d2_acc = 12'h0;
   logic [19:0] d2_clkc = 20'h0;
   logic        d2_cpu_start, d2_cpu_reset, d2_tx_start, d2_busy, d2_ovr;
   logic [7:0]  d2_dout;

   always #5 clk = ~clk;

   uart_cpu_bridge dut (
      .i_clk(clk), .i_reset(rst), .i_rx_done_tick(rx_tick), .i_rx_data_in(rx_dat),
      .i_tx_done_tick(tx_tick), .i_cpu_done(cpu_done), .i_in_acc(acc), .i_in_clk_count(clkc),
      .o_cpu_start(cpu_start), .o_cpu_reset(cpu_reset), .o_tx_start(tx_start),
      .o_data_out(dout), .o_busy(busy), .o_rx_overrun(ovr));

   uart_cpu_bridge #(.LEN_ACC(12), .LEN_CLK(20)) dut2 (
      .i_clk(clk), .i_reset(rst), .i_rx_done_tick(d2_rx_tick), .i_rx_data_in(d2_rx_dat),
      .i_tx_done_tick(d2_tx_tick), .i_cpu_done(d2_cpu_done), .i_in_acc(d2_acc), .i_in_clk_count(d2_clkc),
      .o_cpu_start(d2_cpu_start), .o_cpu_reset(d2_cpu_reset), .o_tx_start(d2_tx_start),
      .o_data_out(d2_dout), .o_busy(d2_busy), .o_rx_overrun(d2_ovr));

   int n_vec = 0, n_err = 0, cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Pulse monitor: counts rising pulses, stamps their cycle, captures TX bytes.
   int n_cs = 0, n_cr = 0, n_ts = 0, cs_cyc = 0, cr_cyc = 0, ts_cyc = 0, long_pulse = 0;
   logic p_cs = 1'b0, p_cr = 1'b0, p_ts = 1'b0;
   logic [7:0] got_q[$];

   always @(negedge clk) begin
      if (cpu_start === 1'b1) begin
         if (p_cs) long_pulse++;
         else begin n_cs++; cs_cyc = cyc; end
      end
      if (cpu_reset === 1'b1) begin
         if (p_cr) long_pulse++;
         else begin n_cr++; cr_cyc = cyc; end
      end
      if (tx_start === 1'b1) begin
         if (p_ts) long_pulse++;
         else begin n_ts++; ts_cyc = cyc; got_q.push_back(dout); end
      end
      p_cs = (cpu_start === 1'b1);
      p_cr = (cpu_reset === 1'b1);
      p_ts = (tx_start === 1'b1);
   end

   // Reference model: last captured result and sticky overrun flag.
   logic [15:0] m_acc = 16'h0, m_clk = 16'h0;
   logic        m_ovr = 1'b0;
   logic [7:0]  exp_q[$];

   function automatic void fill_exp(input logic [31:0] a, input logic [31:0] c, input int la, input int lc);
      logic [7:0] x;
      x = 8'h00;
      exp_q.delete();
      for (int k = 0; k < (la + 7) / 8; k++) exp_q.push_back(8'((a >> (8 * k)) & 32'hFF));
      for (int k = 0; k < (lc + 7) / 8; k++) exp_q.push_back(8'((c >> (8 * k)) & 32'hFF));
`ifdef UART_CPU_BRIDGE_CHECKSUM_EN
      foreach (exp_q[k]) x = x ^ exp_q[k];
      exp_q.push_back(x);
`endif
   endfunction

   task automatic send_rx(input logic [7:0] code, output int t);
      rx_dat  = code;
      rx_tick = 1'b1;
      t = cyc;
      repeat ($urandom_range(1, 2)) step();
      rx_tick = 1'b0;
   endtask

   // inject: 0 none, 1 extra command during RUN, 2 command coinciding with 2nd tx_done.
   task automatic do_job(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] c,
                         input int inject, input int abort_idx);
      int t_ref, t_prev, base_ts, base_cs, guard, nexp;
      logic [7:0] held;
      logic moved;
      if (cmd == 8'h01) begin m_acc = a; m_clk = c; end
      fill_exp(32'(m_acc), 32'(m_clk), 16, 16);
      nexp = exp_q.size();
      base_ts = n_ts;
      base_cs = n_cs;
      got_q.delete();
      send_rx(cmd, t_ref);
      t_prev = t_ref;
      if (cmd == 8'h01) begin
         guard = 0;
         while (n_cs == base_cs && guard < 10) begin step(); guard++; end
         chk("cpu_start_seen", 32'(n_cs - base_cs), 1);
         chk("cpu_start_lat", 32'(cs_cyc - t_ref), 1);
         chk("busy_run", 32'(busy), 1);
         repeat ($urandom_range(1, 3)) step();
         if (inject == 1) begin
            rx_dat = 8'h01; rx_tick = 1'b1; m_ovr = 1'b1;
            step();
            rx_tick = 1'b0;
            chk("ovr_in_run", 32'(ovr), 1);
            step();
         end
         acc = a; clkc = c; cpu_done = 1'b1;
         t_prev = cyc;
      end
      for (int i = 0; i < nexp; i++) begin
         guard = 0;
         while (n_ts <= base_ts + i && guard < 20) begin step(); guard++; end
         chk("tx_start_seen", 32'(n_ts > base_ts + i), 1);
         if (n_ts <= base_ts + i) break;
         chk("tx_start_lat", 32'(ts_cyc - t_prev), 2);
         cpu_done = 1'b0; acc = 16'($urandom); clkc = 16'($urandom);
         held = dout;
         moved = 1'b0;
         if (i == abort_idx) begin
            step();
            rst = 1'b1;
            #1;
            chk("abort_outs", 32'({cpu_start, cpu_reset, tx_start, busy, ovr, dout}), 0);
            m_acc = 16'h0; m_clk = 16'h0; m_ovr = 1'b0;
            step();
            rst = 1'b0;
            step();
            return;
         end
         repeat ($urandom_range(0, 3)) begin
            step();
            if (dout !== held) moved = 1'b1;
         end
         chk("dout_hold", 32'(moved), 0);
         if (i == nexp - 1) chk("busy_before_last", 32'(busy), 1);
         tx_tick = 1'b1;
         t_prev = cyc;
         if (inject == 2 && i == 1) begin rx_dat = 8'h01; rx_tick = 1'b1; m_ovr = 1'b1; end
         step();
         rx_tick = 1'b0;
         if (i == nexp - 1) chk("busy_after_last", 32'(busy), 0);
         repeat ($urandom_range(0, 1)) step();
         tx_tick = 1'b0;
      end
      repeat (6) step();
      chk("tx_count", 32'(n_ts - base_ts), 32'(nexp));
      chk("cpu_start_count", 32'(n_cs - base_cs), (cmd == 8'h01) ? 32'd1 : 32'd0);
      for (int i = 0; i < nexp; i++)
         chk($sformatf("byte%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
      chk("overrun", 32'(ovr), 32'(m_ovr));
   endtask

   task automatic do_reset_cmd();
      int t, base;
      base = n_cr;
      send_rx(8'h02, t);
      step();
      chk("cpu_reset_seen", 32'(n_cr - base), 1);
      chk("cpu_reset_lat", 32'(cr_cyc - t), 1);
      m_ovr = 1'b0;
      chk("ovr_cleared", 32'(ovr), 32'(m_ovr));
      chk("busy_after_reset_cmd", 32'(busy), 0);
   endtask

   task automatic do_junk(input logic [7:0] code);
      int t, bts, bcs, bcr;
      logic [7:0] held;
      bts = n_ts; bcs = n_cs; bcr = n_cr; held = dout;
      send_rx(code, t);
      repeat (6) step();
      chk("junk_quiet", 32'((n_ts - bts) + (n_cs - bcs) + (n_cr - bcr) + int'(busy)), 0);
      chk("junk_dout", 32'(dout), 32'(held));
   endtask

   task automatic d2_run();
      int guard;
      fill_exp(32'h00000ABC, 32'h00012345, 12, 20);
      d2_rx_dat = 8'h01; d2_rx_tick = 1'b1;
      step(); step();
      d2_rx_tick = 1'b0;
      step();
      d2_acc = 12'hABC; d2_clkc = 20'h12345; d2_cpu_done = 1'b1;
      foreach (exp_q[i]) begin
         guard = 0;
         while (d2_tx_start !== 1'b1 && guard < 20) begin step(); guard++; end
         chk("d2_tx_seen", 32'(d2_tx_start), 1);
         chk($sformatf("d2_byte%0d", i), 32'(d2_dout), 32'(exp_q[i]));
         d2_cpu_done = 1'b0;
         step();
         d2_tx_tick = 1'b1;
         step();
         d2_tx_tick = 1'b0;
      end
      repeat (4) step();
      chk("d2_busy_end", 32'(d2_busy), 0);
   endtask

   initial begin
      int r;
      #1 rst = 1'b1;
      repeat (3) step();
      chk("reset_outs_held", 32'({cpu_start, cpu_reset, tx_start, busy, ovr, dout}), 0);
      rst = 1'b0;
      step();
      chk("reset_outs", 32'({cpu_start, cpu_reset, tx_start, busy, ovr, dout}), 0);
      chk("reset_outs_d2", 32'({d2_cpu_start, d2_cpu_reset, d2_tx_start, d2_busy, d2_ovr, d2_dout}), 0);

      do_job(8'h01, 16'hBEEF, 16'h0023, 0, -1);
      do_job(8'h03, 16'($urandom), 16'($urandom), 0, -1);
      do_job(8'h01, 16'($urandom), 16'($urandom), 1, -1);
      do_reset_cmd();
      do_junk(8'h7F);
      do_job(8'h01, 16'($urandom), 16'($urandom), 2, -1);
      do_reset_cmd();
      do_job(8'h01, 16'hBEEF, 16'h0023, 0, 2);
      do_job(8'h03, 16'h0, 16'h0, 0, -1);

      for (int n = 0; n < 24; n++) begin
         r = $urandom_range(0, 9);
         if (r < 5)      do_job(8'h01, 16'($urandom), 16'($urandom), $urandom_range(0, 2), -1);
         else if (r < 7) do_job(8'h03, 16'h0, 16'h0, 2 * $urandom_range(0, 1), -1);
         else if (r < 9) do_reset_cmd();
         else            do_junk(8'($urandom_range(4, 255)));
      end

      d2_run();
      chk("pulse_width", 32'(long_pulse), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
